// File: rtl/axi_interconnect_pkg.sv
// Shared types for the 4-master AXI4 interconnect arbiters.
package axi_interconnect_pkg;

    localparam int unsigned NUM_MASTERS = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_AR,
        ARB_R
    } arb_state_e;

    typedef logic [NUM_MASTERS-1:0] grant_t;

    function automatic logic [1:0] onehot_to_idx(input grant_t g);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (g[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_arbiter_r_if.sv
// Read-channel arbiter bundle: raw AR requests, shared R handshakes and one-hot grants.
interface axi_arbiter_r_if;

    logic m0_ARVALID;
    logic m1_ARVALID;
    logic m2_ARVALID;
    logic m3_ARVALID;
    logic m_ARREADY;
    logic m_RVALID;
    logic m_RLAST;
    logic s_RREADY;
    logic m0_rgrnt;
    logic m1_rgrnt;
    logic m2_rgrnt;
    logic m3_rgrnt;
    logic rbusy;

    // Interconnect side: drives requests/handshakes, consumes grants.
    modport master (
        output m0_ARVALID, m1_ARVALID, m2_ARVALID, m3_ARVALID,
        output m_ARREADY, m_RVALID, m_RLAST, s_RREADY,
        input  m0_rgrnt, m1_rgrnt, m2_rgrnt, m3_rgrnt, rbusy
    );

    // Arbiter side.
    modport slave (
        input  m0_ARVALID, m1_ARVALID, m2_ARVALID, m3_ARVALID,
        input  m_ARREADY, m_RVALID, m_RLAST, s_RREADY,
        output m0_rgrnt, m1_rgrnt, m2_rgrnt, m3_rgrnt, rbusy
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational winner picker: round-robin behind last_owner, or fixed m0-highest.
module rr_priority_picker
    import axi_interconnect_pkg::*;
(
    input  grant_t     i_req,
    input  logic [1:0] i_last_owner,
    input  logic       i_rr_enable,
    output grant_t     o_grant,
    output logic       o_valid
);

    logic [1:0] w_idx;
    logic       w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        // Round-robin scans last_owner+1 .. last_owner+4 (wrapping), fixed scans 0..3.
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_idx = i_rr_enable ? (i_last_owner + 2'(k + 1)) : 2'(k);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/axi_arbiter_r.sv
// AXI4 read-channel arbiter: one owner from AR grant through the RLAST handshake.
module axi_arbiter_r
    import axi_interconnect_pkg::*;
#(
    parameter int unsigned RR_ENABLE = 1
) (
    input  logic           ACLK,
    input  logic           ARESETn,
    axi_arbiter_r_if.slave bus
);

    arb_state_e r_state;
    arb_state_e w_state_d;
    grant_t     r_grant;
    grant_t     w_grant_d;
    logic [1:0] r_last_owner;
    logic [1:0] w_last_owner_d;
    logic       r_rbusy;

    grant_t     w_req;
    grant_t     w_pick;
    logic       w_pick_valid;
    logic       w_ar_hs;
    logic       w_rlast_hs;

    assign w_req = {bus.m3_ARVALID, bus.m2_ARVALID, bus.m1_ARVALID, bus.m0_ARVALID};

    rr_priority_picker u_picker (
        .i_req        (w_req),
        .i_last_owner (r_last_owner),
        .i_rr_enable  (RR_ENABLE != 0),
        .o_grant      (w_pick),
        .o_valid      (w_pick_valid)
    );

    // Only the granted master's ARVALID can complete the AR handshake.
    assign w_ar_hs    = (|(r_grant & w_req)) && bus.m_ARREADY;
    assign w_rlast_hs = bus.m_RVALID && bus.s_RREADY && bus.m_RLAST;

    always_comb begin
        w_state_d      = r_state;
        w_grant_d      = r_grant;
        w_last_owner_d = r_last_owner;
        case (r_state)
            ARB_IDLE: begin
                w_grant_d = '0;
                if (w_pick_valid) begin
                    w_state_d      = ARB_AR;
                    w_grant_d      = w_pick;
                    w_last_owner_d = onehot_to_idx(w_pick);
                end
            end
            ARB_AR: begin
                if (w_ar_hs) w_state_d = ARB_R;
            end
            ARB_R: begin
                if (w_rlast_hs) begin
                    w_state_d = ARB_IDLE;
                    w_grant_d = '0;
                end
            end
            default: begin
                w_state_d = ARB_IDLE;
                w_grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state      <= ARB_IDLE;
            r_grant      <= '0;
            r_last_owner <= 2'd3;
            r_rbusy      <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_grant      <= w_grant_d;
            r_last_owner <= w_last_owner_d;
            r_rbusy      <= |w_grant_d;
        end
    end

    assign bus.m0_rgrnt = r_grant[0];
    assign bus.m1_rgrnt = r_grant[1];
    assign bus.m2_rgrnt = r_grant[2];
    assign bus.m3_rgrnt = r_grant[3];
    assign bus.rbusy    = r_rbusy;

endmodule
